alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Multi-cycle ALU that consumes the 4-bit ALUSel code produced by the instruction decoder, and executes the R-type operation on two 32-bit operands.
- Shifts are iterative: one bit position per cycle. This keeps the barrel shifter out of the datapath for the low-area core variant.
- All other operations complete in one compute cycle.
- Sits between the register-file read stage and writeback, with valid/ready handshakes on both sides.

Parameters:
- DWIDTH, 32, operand and result width.
- SWIDTH, 4, ALUSel width.
- SHW, 5, shift-amount width (log2 DWIDTH).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and ALUSel present.
- in_ready  out  1  block can accept a new operation.
- alu_sel  in  SWIDTH  operation code, encoding below.
- op_a  in  DWIDTH  operand A (rs1).
- op_b  in  DWIDTH  operand B (rs2); b[SHW-1:0] is the shift amount.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  DWIDTH  operation result.
- zero  out  1  result == 0.
- illegal  out  1  alu_sel was not a defined code.

Behaviour:
- ALUSel encoding:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0100 SLT, 0110 SLTU
  - 1000 XOR, 1010 SRL, 1011 SRA, 1100 OR, 1110 AND
  - All other codes are illegal.
- Reset (rst=1 at an edge): state=IDLE; result=0; zero=0; illegal=0; out_valid=0. in_ready=1 in the cycle after reset deasserts. Reset mid-operation abandons the operation with no output.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch alu_sel, op_a, op_b.
  - Non-shift or illegal op: compute and register result, go to DONE.
  - Shift op with shamt==0: result=op_a, go to DONE.
  - Shift op with shamt!=0: load the shift register with op_a and the counter with shamt, go to SHIFT.
- SHIFT:
  - Each cycle, shift by 1: SLL inserts 0 at LSB; SRL inserts 0 at MSB; SRA replicates the MSB.
  - Decrement the counter. Go to DONE when the counter hits 1 (i.e., after the last shift).
  - in_ready=0.
- DONE:
  - out_valid=1; result, zero and illegal held stable.
  - Leave on out_valid&&out_ready to IDLE.
  - No input is accepted in DONE.
- Latency (accept edge to first out_valid cycle):
  - 1 cycle for non-shift ops and for shamt=0.
  - 1+shamt cycles for shifts with shamt≥1; maximum 32.
- Throughput: at most one op every 2 cycles, since in_ready and out_valid are never high together.
- Arithmetic:
  - ADD and SUB wrap modulo 2^DWIDTH.
  - SLT compares signed; SLTU compares unsigned; both give result 0 or 1, zero-extended.
  - Only b[4:0] is used for shifts; b[31:5] is ignored.
- Illegal code: result=0, zero=1, illegal=1, latency 1.
- Handshake rules:
  - in_valid with in_ready=0 is ignored; the source holds its inputs.
  - out_ready while out_valid=0 is ignored.
  - Output fields are frozen while out_valid=1 && out_ready=0.
- Inputs changing during SHIFT or DONE have no effect, because operands are latched at accept.

Decomposition:
- Shared package alu_pkg:
  - SWIDTH.
  - Named ALUSel constants (ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND).
  - FSM state enum.
  - is_shift function.
- The package is also imported by the decoder so both ends share one encoding.
- One sub-module, alu_comb: purely combinational single-cycle ops (add/sub/slt/sltu/xor/or/and plus illegal detect). The FSM, shift register and counter stay in alu_seq.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready=1 → out_valid 1 cycle after accept; result=0x80000000, zero=0, illegal=0.
- SUB 5-5 then SLT 0xFFFFFFFF vs 0x00000001 → first result=0, zero=1; SLT result=1; SLTU on the same operands result=0.
- SRA op_a=0x80000000, op_b=0x0000001F → out_valid exactly 32 cycles after accept; result=0xFFFFFFFF. SRL on the same operands gives 0x00000001. SLL 0x1 by b=0x00000020 (shamt 0) → result=0x1, latency 1.
- Backpressure: SLL 0x3 by 4 with out_ready=0 for 5 cycles → result=0x30 held stable, in_ready=0 throughout; accepted on the out_ready rise; in_ready=1 the next cycle.
- Illegal alu_sel=0011 → result=0, zero=1, illegal=1; the next legal op clears illegal.
- rst pulsed during SHIFT of an SRL by 20 → next cycle state IDLE, out_valid=0, result=0, in_ready=1; the aborted op never produces out_valid.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALUSel encoding, FSM state type and helpers for the sequential ALU.
// The instruction decoder imports this package too, so both ends share one encoding.
package alu_pkg;

   localparam int SWIDTH = 4;

   localparam logic [SWIDTH-1:0] ALU_ADD  = 4'b0000;
   localparam logic [SWIDTH-1:0] ALU_SUB  = 4'b0001;
   localparam logic [SWIDTH-1:0] ALU_SLL  = 4'b0010;
   localparam logic [SWIDTH-1:0] ALU_SLT  = 4'b0100;
   localparam logic [SWIDTH-1:0] ALU_SLTU = 4'b0110;
   localparam logic [SWIDTH-1:0] ALU_XOR  = 4'b1000;
   localparam logic [SWIDTH-1:0] ALU_SRL  = 4'b1010;
   localparam logic [SWIDTH-1:0] ALU_SRA  = 4'b1011;
   localparam logic [SWIDTH-1:0] ALU_OR   = 4'b1100;
   localparam logic [SWIDTH-1:0] ALU_AND  = 4'b1110;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } alu_state_e;

   function automatic logic is_shift(input logic [SWIDTH-1:0] sel);
      return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations and illegal-code detection; purely combinational.
// Shift codes are legal here but produce no result: alu_seq shifts iteratively.
module alu_comb
   import alu_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic [SWIDTH-1:0] i_sel,
   input  logic [DWIDTH-1:0] i_a,
   input  logic [DWIDTH-1:0] i_b,
   output logic [DWIDTH-1:0] o_result,
   output logic              o_illegal
);

   // NOTE: every output gets a default before the case, so no path can infer a latch.
   always_comb begin
      o_result  = '0;
      o_illegal = 1'b0;
      case (i_sel)
         ALU_ADD:  o_result = i_a + i_b;
         ALU_SUB:  o_result = i_a - i_b;
         ALU_SLT:  o_result = {{(DWIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         ALU_SLTU: o_result = {{(DWIDTH-1){1'b0}}, (i_a < i_b)};
         ALU_XOR:  o_result = i_a ^ i_b;
         ALU_OR:   o_result = i_a | i_b;
         ALU_AND:  o_result = i_a & i_b;
         ALU_SLL, ALU_SRL, ALU_SRA: o_result = '0;
         default:  o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops via alu_comb, shifts one bit per cycle.
// Valid/ready on both sides; in_ready and out_valid are never high together.
module alu_seq
   import alu_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int SHW    = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [SWIDTH-1:0] alu_sel,
   input  logic [DWIDTH-1:0] op_a,
   input  logic [DWIDTH-1:0] op_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] result,
   output logic              zero,
   output logic              illegal
);

   alu_state_e        r_state;
   alu_state_e        w_state_next;
   logic [SWIDTH-1:0] r_sel;
   logic [DWIDTH-1:0] r_shreg;
   logic [SHW-1:0]    r_cnt;
   logic [DWIDTH-1:0] r_result;
   logic              r_zero;
   logic              r_illegal;

   logic [DWIDTH-1:0] w_comb_result;
   logic              w_comb_illegal;
   logic [DWIDTH-1:0] w_shift_next;
   logic [SHW-1:0]    w_shamt;
   logic              w_accept;
   logic              w_last_shift;

   alu_comb #(.DWIDTH(DWIDTH)) u_alu_comb (
      .i_sel     (alu_sel),
      .i_a       (op_a),
      .i_b       (op_b),
      .o_result  (w_comb_result),
      .o_illegal (w_comb_illegal)
   );

   assign w_shamt      = op_b[SHW-1:0];
   assign w_accept     = (r_state == ST_IDLE) && in_valid;
   assign w_last_shift = (r_state == ST_SHIFT) && (r_cnt == SHW'(1));

   always_comb begin
      w_shift_next = r_shreg;
      case (r_sel)
         ALU_SLL: w_shift_next = {r_shreg[DWIDTH-2:0], 1'b0};
         ALU_SRL: w_shift_next = {1'b0, r_shreg[DWIDTH-1:1]};
         ALU_SRA: w_shift_next = {r_shreg[DWIDTH-1], r_shreg[DWIDTH-1:1]};
         default: w_shift_next = r_shreg;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (is_shift(alu_sel) && (w_shamt != '0)) w_state_next = ST_SHIFT;
               else                                       w_state_next = ST_DONE;
            end
         end
         ST_SHIFT: begin
            if (r_cnt == SHW'(1)) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel     <= ALU_ADD;
         r_shreg   <= '0;
         r_cnt     <= '0;
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
      end else if (w_accept) begin
         r_sel <= alu_sel;
         if (!is_shift(alu_sel)) begin
            r_result  <= w_comb_result;
            r_zero    <= (w_comb_result == '0);
            r_illegal <= w_comb_illegal;
         end else if (w_shamt == '0) begin
            r_result  <= op_a;
            r_zero    <= (op_a == '0);
            r_illegal <= 1'b0;
         end else begin
            r_shreg <= op_a;
            r_cnt   <= w_shamt;
         end
      end else if (r_state == ST_SHIFT) begin
         r_shreg <= w_shift_next;
         r_cnt   <= r_cnt - SHW'(1);
         // The last shift writes straight into the result so DONE presents it at once.
         if (w_last_shift) begin
            r_result  <= w_shift_next;
            r_zero    <= (w_shift_next == '0);
            r_illegal <= 1'b0;
         end
      end
   end

   assign result  = r_result;
   assign zero    = r_zero;
   assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a driver pushes model predictions, a monitor
// pops them when the DUT presents a result and checks value, flags and latency.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_sel;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        ill;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_mis = 0;
   int   cyc   = 0;
   logic rdy_rand_en = 1'b0;

   alu_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_sel   (alu_sel),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: RISC-V R-type semantics written with plain arithmetic.
   function automatic exp_t model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   sh;
      logic shift_op;
      sh       = int'(b[4:0]);
      shift_op = 1'b0;
      e.ill    = 1'b0;
      case (sel)
         4'b0000: e.res = a + b;
         4'b0001: e.res = a - b;
         4'b0100: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b0110: e.res = (a < b) ? 32'd1 : 32'd0;
         4'b1000: e.res = a ^ b;
         4'b1100: e.res = a | b;
         4'b1110: e.res = a & b;
         4'b0010: begin e.res = a << sh; shift_op = 1'b1; end
         4'b1010: begin e.res = a >> sh; shift_op = 1'b1; end
         4'b1011: begin e.res = $signed(a) >>> sh; shift_op = 1'b1; end
         default: begin e.res = 32'd0; e.ill = 1'b1; end
      endcase
      e.z   = (e.res == 32'd0);
      e.lat = (shift_op && sh != 0) ? sh + 1 : 1;
      e.acc = 0;
      return e;
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   n;
      n        = 0;
      in_valid = 1'b1;
      alu_sel  = sel;
      op_a     = a;
      op_b     = b;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            @(posedge clk); #1;
            return;
         end
      end
      e     = model(sel, a, b);
      e.acc = cyc;
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      alu_sel  = 4'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("drain_timeout", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rdy_rand_en) out_ready = ($urandom_range(0, 2) != 0);
      end
   end

   // Monitor: pops a prediction on the first out_valid cycle, then checks
   // stability under backpressure and in_ready after each handshake.
   initial begin : monitor
      exp_t        cur;
      bit          seen;
      bit          post_hs;
      logic [31:0] held_res;
      logic        held_z;
      logic        held_ill;
      seen    = 0;
      post_hs = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            seen    = 0;
            post_hs = 0;
            continue;
         end
         if (post_hs) begin
            check("in_ready_after_hs", 32'(in_ready), 32'd1);
            check("out_valid_after_hs", 32'(out_valid), 32'd0);
            post_hs = 0;
         end
         if (out_valid) begin
            if (!seen) begin
               if (sb.size() == 0) begin
                  check("unexpected_out_valid", 32'(out_valid), 32'd0);
               end else begin
                  cur = sb.pop_front();
                  check("result", result, cur.res);
                  check("zero", 32'(zero), 32'(cur.z));
                  check("illegal", 32'(illegal), 32'(cur.ill));
                  check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
               end
               seen     = 1;
               held_res = result;
               held_z   = zero;
               held_ill = illegal;
            end else begin
               check("result_stable", result, held_res);
               check("flags_stable", {30'd0, zero, illegal}, {30'd0, held_z, held_ill});
            end
            check("in_ready_while_valid", 32'(in_ready), 32'd0);
            if (out_ready) begin
               seen    = 0;
               post_hs = 1;
            end
         end
      end
   end

   initial begin
      int n;
      rst       = 1'b1;
      in_valid  = 1'b0;
      alu_sel   = 4'd0;
      op_a      = 32'd0;
      op_b      = 32'd0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_flags", {30'd0, zero, illegal}, 32'd0);
      @(posedge clk); #1;

      // Directed cases
      issue(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
      issue(4'b0001, 32'd5, 32'd5);
      issue(4'b0100, 32'hFFFF_FFFF, 32'h0000_0001);
      issue(4'b0110, 32'hFFFF_FFFF, 32'h0000_0001);
      issue(4'b1011, 32'h8000_0000, 32'h0000_001F);
      issue(4'b1010, 32'h8000_0000, 32'h0000_001F);
      issue(4'b0010, 32'h0000_0001, 32'h0000_0020);
      issue(4'b0011, 32'h1234_5678, 32'h9ABC_DEF0);
      issue(4'b1110, 32'hF0F0_F0F0, 32'hFF00_FF00);
      drain();

      // Backpressure: hold out_ready low for five valid cycles
      out_ready = 1'b0;
      issue(4'b0010, 32'h0000_0003, 32'h0000_0004);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 50);
      check("bp_valid_seen", 32'(out_valid), 32'd1);
      repeat (4) @(posedge clk);
      #1 out_ready = 1'b1;
      drain();

      // Reset in the middle of an SRL by 20: the op must never complete
      issue(4'b1010, 32'hDEAD_BEEF, 32'd20);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_result", result, 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      repeat (30) @(posedge clk);
      #1;

      // Randomized traffic with random backpressure
      rdy_rand_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         logic [31:0] b;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) b[4:0] = 5'($urandom_range(0, 2));
         issue(4'($urandom_range(0, 15)), $urandom, b);
      end
      drain();
      rdy_rand_en = 1'b0;
      out_ready   = 1'b1;
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
